// File: rtl/kinase_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kinase_seq_pkg
//  Description : Shared types and line-value constants for the kinase valve
//                sequencer: FSM state encoding, pump_a phase table and the
//                closed / vented / flush line values.
//  Revision    : 1.0 - initial release
// ============================================================================
package kinase_seq_pkg;

    // Run sequence: IDLE -> SETTLE -> PUMP -> DRAIN -> FLUSH -> DONE -> IDLE
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_PUMP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_t;

    localparam int C_NUM_PHASES = 6;

    // Peristaltic pump_a pattern, entry 0 in the least significant slot:
    // 101, 100, 110, 010, 011, 001 (1 = chamber closed)
    localparam logic [5:0][2:0] C_PUMP_A_TABLE = {
        3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101
    };

    // Closed lines are pressurised (all ones)
    localparam logic [12:0] C_CTRL_A_CLOSED = 13'h1FFF;
    localparam logic [3:0]  C_CTRL_S_CLOSED = 4'hF;
    localparam logic [2:0]  C_PUMP_A_CLOSED = 3'b111;
    localparam logic [1:0]  C_PUMP_B_CLOSED = 2'b11;

    // Vented lines carry no pressure
    localparam logic [12:0] C_CTRL_A_VENTED = 13'h0000;
    localparam logic [3:0]  C_CTRL_S_VENTED = 4'h0;
    localparam logic [2:0]  C_PUMP_A_VENTED = 3'b000;
    localparam logic [1:0]  C_PUMP_B_VENTED = 2'b00;

    // Flush pressure applied / released
    localparam logic [12:0] C_FLUSH_CTRL_A_ON = 13'h1FFF;
    localparam logic [3:0]  C_FLUSH_CTRL_S_ON = 4'hF;
    localparam logic [2:0]  C_FLUSH_PUMP_A_ON = 3'b111;
    localparam logic [1:0]  C_FLUSH_PUMP_B_ON = 2'b11;

    // Pump_b pattern on even / odd strokes
    localparam logic [1:0]  C_PUMP_B_EVEN = 2'b10;
    localparam logic [1:0]  C_PUMP_B_ODD  = 2'b01;

    // One-hot route select for the ctrl_s output bank
    function automatic logic [3:0] route_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/peristaltic_phase_gen.sv
`default_nettype none
// ============================================================================
//  Module      : peristaltic_phase_gen
//  Description : PUMP_DIV clock divider, 6-step pump phase index and stroke
//                counter for the peristaltic pump. Counts only while enabled
//                and returns to phase 0 / stroke 0 whenever disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module peristaltic_phase_gen
    import kinase_seq_pkg::*;
#(
    parameter int PUMP_DIV     = 1000,
    parameter int PUMP_STROKES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_enable,
    output logic [2:0] o_phase_idx,
    output logic       o_odd_stroke,
    output logic       o_last_stroke,
    output logic       o_phase_end
);

    localparam int DW = $clog2(PUMP_DIV) + 1;
    localparam int KW = $clog2(PUMP_STROKES) + 1;

    localparam logic [DW-1:0] C_DIV_LAST    = DW'(PUMP_DIV - 1);
    localparam logic [KW-1:0] C_STROKE_LAST = KW'(PUMP_STROKES - 1);
    localparam logic [2:0]    C_PHASE_LAST  = 3'(C_NUM_PHASES - 1);

    logic [DW-1:0] r_div;
    logic [2:0]    r_phase;
    logic [KW-1:0] r_stroke;

    logic w_div_tc;
    logic w_phase_wrap;
    logic w_stroke_wrap;

    assign w_div_tc      = (r_div == C_DIV_LAST);
    assign w_phase_wrap  = (r_phase == C_PHASE_LAST);
    assign w_stroke_wrap = (r_stroke == C_STROKE_LAST);

    // Divider -> phase -> stroke cascade; cleared while the pump is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div    <= '0;
            r_phase  <= '0;
            r_stroke <= '0;
        end else if (!i_enable) begin
            r_div    <= '0;
            r_phase  <= '0;
            r_stroke <= '0;
        end else if (w_div_tc) begin
            r_div <= '0;
            if (w_phase_wrap) begin
                r_phase  <= '0;
                r_stroke <= w_stroke_wrap ? '0 : r_stroke + KW'(1);
            end else begin
                r_phase <= r_phase + 3'd1;
            end
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    assign o_phase_idx   = r_phase;
    assign o_odd_stroke  = r_stroke[0];
    assign o_last_stroke = w_stroke_wrap;
    assign o_phase_end   = i_enable & w_div_tc & w_phase_wrap;

endmodule
`default_nettype wire

// File: rtl/kinase_valve_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : kinase_valve_sequencer
//  Description : Valve / pump sequencer for the kinase activity bank pad ring.
//                One run: settle routing, pump a fixed number of peristaltic
//                strokes, drain, flush, then pulse done. Every output is
//                registered from the current state, so outputs trail the
//                state register by one clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module kinase_valve_sequencer
    import kinase_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 200,
    parameter int PUMP_DIV      = 1000,
    parameter int PUMP_STROKES  = 16,
    parameter int FLUSH_CYCLES  = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [12:0] ctrl_a_mask,
    input  logic [1:0]  sel_out,
    output logic        busy,
    output logic        done,
    output logic [12:0] ctrl_a,
    output logic [3:0]  ctrl_s,
    output logic [2:0]  pump_a,
    output logic [1:0]  pump_b,
    output logic [12:0] flush_ctrl_a,
    output logic [3:0]  flush_ctrl_s,
    output logic [2:0]  flush_pump_a,
    output logic [1:0]  flush_pump_b
);

    localparam int SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int FW = $clog2(FLUSH_CYCLES) + 1;

    localparam logic [SW-1:0] C_SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [FW-1:0] C_FLUSH_LAST  = FW'(FLUSH_CYCLES - 1);

    seq_state_t    r_state;
    seq_state_t    w_next_state;

    logic [12:0]   r_mask;
    logic [1:0]    r_sel;
    logic [SW-1:0] r_settle_cnt;
    logic [FW-1:0] r_flush_cnt;

    logic          w_settle_tc;
    logic          w_flush_tc;
    logic          w_pump_done;

    logic [2:0]    w_phase_idx;
    logic          w_odd_stroke;
    logic          w_last_stroke;
    logic          w_phase_end;

    logic          w_busy;
    logic          w_done;
    logic [12:0]   w_ctrl_a;
    logic [3:0]    w_ctrl_s;
    logic [2:0]    w_pump_a;
    logic [1:0]    w_pump_b;
    logic [12:0]   w_flush_ctrl_a;
    logic [3:0]    w_flush_ctrl_s;
    logic [2:0]    w_flush_pump_a;
    logic [1:0]    w_flush_pump_b;

    peristaltic_phase_gen #(
        .PUMP_DIV     (PUMP_DIV),
        .PUMP_STROKES (PUMP_STROKES)
    ) u_phase_gen (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (r_state == ST_PUMP),
        .o_phase_idx   (w_phase_idx),
        .o_odd_stroke  (w_odd_stroke),
        .o_last_stroke (w_last_stroke),
        .o_phase_end   (w_phase_end)
    );

    assign w_settle_tc = (r_settle_cnt == C_SETTLE_LAST);
    assign w_flush_tc  = (r_flush_cnt == C_FLUSH_LAST);
    assign w_pump_done = w_phase_end & w_last_stroke;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; abort only matters while fluid is being routed
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort)            w_next_state = ST_FLUSH;
                else if (w_settle_tc) w_next_state = ST_PUMP;
            end
            ST_PUMP: begin
                if (abort)            w_next_state = ST_FLUSH;
                else if (w_pump_done) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort)            w_next_state = ST_FLUSH;
                else if (w_settle_tc) w_next_state = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (w_flush_tc) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Settle/drain timer: counts while staying in SETTLE or DRAIN, else zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle_cnt <= '0;
        end else if ((r_state == ST_SETTLE || r_state == ST_DRAIN) &&
                     (w_next_state == r_state)) begin
            r_settle_cnt <= r_settle_cnt + SW'(1);
        end else begin
            r_settle_cnt <= '0;
        end
    end

    // Flush timer: zero on entry so an abort always gets the full flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_cnt <= '0;
        end else if ((r_state == ST_FLUSH) && (w_next_state == ST_FLUSH)) begin
            r_flush_cnt <= r_flush_cnt + FW'(1);
        end else begin
            r_flush_cnt <= '0;
        end
    end

    // Run configuration captured only when a run is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '0;
            r_sel  <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_mask <= ctrl_a_mask;
            r_sel  <= sel_out;
        end
    end

    // Output decode from the current state
    always_comb begin
        w_busy         = 1'b0;
        w_done         = 1'b0;
        w_ctrl_a       = C_CTRL_A_CLOSED;
        w_ctrl_s       = C_CTRL_S_CLOSED;
        w_pump_a       = C_PUMP_A_CLOSED;
        w_pump_b       = C_PUMP_B_CLOSED;
        w_flush_ctrl_a = '0;
        w_flush_ctrl_s = '0;
        w_flush_pump_a = '0;
        w_flush_pump_b = '0;
        case (r_state)
            ST_SETTLE: begin
                w_busy   = 1'b1;
                w_ctrl_a = ~r_mask;
                w_ctrl_s = ~route_onehot(r_sel);
            end
            ST_PUMP: begin
                w_busy   = 1'b1;
                w_ctrl_a = ~r_mask;
                w_ctrl_s = ~route_onehot(r_sel);
                w_pump_a = C_PUMP_A_TABLE[w_phase_idx];
                w_pump_b = w_odd_stroke ? C_PUMP_B_ODD : C_PUMP_B_EVEN;
            end
            ST_DRAIN: begin
                w_busy   = 1'b1;
                w_ctrl_s = ~route_onehot(r_sel);
            end
            ST_FLUSH: begin
                w_busy         = 1'b1;
                w_ctrl_a       = C_CTRL_A_VENTED;
                w_ctrl_s       = C_CTRL_S_VENTED;
                w_pump_a       = C_PUMP_A_VENTED;
                w_pump_b       = C_PUMP_B_VENTED;
                w_flush_ctrl_a = C_FLUSH_CTRL_A_ON;
                w_flush_ctrl_s = C_FLUSH_CTRL_S_ON;
                w_flush_pump_a = C_FLUSH_PUMP_A_ON;
                w_flush_pump_b = C_FLUSH_PUMP_B_ON;
            end
            ST_DONE: begin
                w_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Output registers; reset drops every line to the safe closed state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            ctrl_a       <= C_CTRL_A_CLOSED;
            ctrl_s       <= C_CTRL_S_CLOSED;
            pump_a       <= C_PUMP_A_CLOSED;
            pump_b       <= C_PUMP_B_CLOSED;
            flush_ctrl_a <= '0;
            flush_ctrl_s <= '0;
            flush_pump_a <= '0;
            flush_pump_b <= '0;
        end else begin
            busy         <= w_busy;
            done         <= w_done;
            ctrl_a       <= w_ctrl_a;
            ctrl_s       <= w_ctrl_s;
            pump_a       <= w_pump_a;
            pump_b       <= w_pump_b;
            flush_ctrl_a <= w_flush_ctrl_a;
            flush_ctrl_s <= w_flush_ctrl_s;
            flush_pump_a <= w_flush_pump_a;
            flush_pump_b <= w_flush_pump_b;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kinase_valve_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kinase_valve_sequencer
//  Description : Directed self-checking bench for kinase_valve_sequencer with
//                SETTLE=3, PUMP_DIV=2, PUMP_STROKES=2, FLUSH=4.
//                Cycle n = outputs observed 1 time unit after edge n, where
//                edge 0 is the edge that samples start.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kinase_valve_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [12:0] ctrl_a_mask;
    logic [1:0]  sel_out;
    logic        busy;
    logic        done;
    logic [12:0] ctrl_a;
    logic [3:0]  ctrl_s;
    logic [2:0]  pump_a;
    logic [1:0]  pump_b;
    logic [12:0] flush_ctrl_a;
    logic [3:0]  flush_ctrl_s;
    logic [2:0]  flush_pump_a;
    logic [1:0]  flush_pump_b;

    int n_checks;
    int n_fail;

    logic [2:0] pump_tbl [6];

    kinase_valve_sequencer #(
        .SETTLE_CYCLES (3),
        .PUMP_DIV      (2),
        .PUMP_STROKES  (2),
        .FLUSH_CYCLES  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .ctrl_a_mask  (ctrl_a_mask),
        .sel_out      (sel_out),
        .busy         (busy),
        .done         (done),
        .ctrl_a       (ctrl_a),
        .ctrl_s       (ctrl_s),
        .pump_a       (pump_a),
        .pump_b       (pump_b),
        .flush_ctrl_a (flush_ctrl_a),
        .flush_ctrl_s (flush_ctrl_s),
        .flush_pump_a (flush_pump_a),
        .flush_pump_b (flush_pump_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic b, input logic d,
                              input logic [12:0] ca, input logic [3:0] cs,
                              input logic [2:0] pa, input logic [1:0] pb,
                              input logic fl);
        logic [21:0] fexp;
        fexp = fl ? 22'h3FFFFF : 22'h0;
        chk({tag, " busy"},   32'(busy),   32'(b));
        chk({tag, " done"},   32'(done),   32'(d));
        chk({tag, " ctrl_a"}, 32'(ctrl_a), 32'(ca));
        chk({tag, " ctrl_s"}, 32'(ctrl_s), 32'(cs));
        chk({tag, " pump_a"}, 32'(pump_a), 32'(pa));
        chk({tag, " pump_b"}, 32'(pump_b), 32'(pb));
        chk({tag, " flush"},
            32'({flush_ctrl_a, flush_ctrl_s, flush_pump_a, flush_pump_b}), 32'(fexp));
    endtask

    task automatic expect_idle(input string tag);
        expect_out(tag, 1'b0, 1'b0, 13'h1FFF, 4'hF, 3'b111, 2'b11, 1'b0);
    endtask

    // Expected outputs at cycle n of an unaborted run:
    // SETTLE 1-3, PUMP 4-27, DRAIN 28-30, FLUSH 31-34, done at 35
    task automatic check_nominal(input string run, input int n,
                                 input logic [12:0] m, input logic [1:0] s);
        string      tag;
        logic [3:0] route;
        int         ph;
        int         stk;
        route = 4'hF;
        route[s] = 1'b0;
        tag = $sformatf("%s n=%0d", run, n);
        if (n == 0 || n >= 36) begin
            expect_idle(tag);
        end else if (n <= 3) begin
            expect_out(tag, 1'b1, 1'b0, ~m, route, 3'b111, 2'b11, 1'b0);
        end else if (n <= 27) begin
            ph  = ((n - 4) / 2) % 6;
            stk = (n - 4) / 12;
            expect_out(tag, 1'b1, 1'b0, ~m, route, pump_tbl[ph],
                       (stk % 2 == 1) ? 2'b01 : 2'b10, 1'b0);
        end else if (n <= 30) begin
            expect_out(tag, 1'b1, 1'b0, 13'h1FFF, route, 3'b111, 2'b11, 1'b0);
        end else if (n <= 34) begin
            expect_out(tag, 1'b1, 1'b0, 13'h0000, 4'h0, 3'b000, 2'b00, 1'b1);
        end else begin
            expect_out(tag, 1'b0, 1'b1, 13'h1FFF, 4'hF, 3'b111, 2'b11, 1'b0);
        end
    endtask

    // Apply start for edge 0, then scramble the config inputs so only the
    // latched copy can produce correct routing
    task automatic launch(input string run, input logic [12:0] m,
                          input logic [1:0] s, input logic ab);
        start       = 1'b1;
        abort       = ab;
        ctrl_a_mask = m;
        sel_out     = s;
        step();
        start       = 1'b0;
        abort       = 1'b0;
        ctrl_a_mask = ~m;
        sel_out     = ~s;
        check_nominal(run, 0, m, s);
    endtask

    // Follow cycles 1..36; optionally request the next run while done shows
    task automatic follow_nominal(input string run, input logic [12:0] m,
                                  input logic [1:0] s, input logic chain,
                                  input logic [12:0] nm, input logic [1:0] ns);
        for (int n = 1; n <= 36; n++) begin
            step();
            if (n == 36) begin
                start       = 1'b0;
                ctrl_a_mask = ~nm;
                sel_out     = ~ns;
            end
            check_nominal(run, n, m, s);
            if (n == 35 && chain) begin
                start       = 1'b1;
                ctrl_a_mask = nm;
                sel_out     = ns;
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        pump_tbl[0] = 3'b101;
        pump_tbl[1] = 3'b100;
        pump_tbl[2] = 3'b110;
        pump_tbl[3] = 3'b010;
        pump_tbl[4] = 3'b011;
        pump_tbl[5] = 3'b001;

        start       = 1'b0;
        abort       = 1'b0;
        ctrl_a_mask = 13'h0;
        sel_out     = 2'd0;
        rst         = 1'b1;

        // Reset values
        step();
        step();
        expect_idle("reset");
        rst = 1'b0;
        step();
        expect_idle("post-reset");

        // Nominal run: mask 0005, sel 2
        launch("nom", 13'h0005, 2'd2, 1'b0);
        follow_nominal("nom", 13'h0005, 2'd2, 1'b0, 13'h0, 2'd0);

        // Abort while pump_a shows phase 3 (010); start during FLUSH ignored
        launch("abt", 13'h1234, 2'd1, 1'b0);
        for (int n = 1; n <= 10; n++) begin
            step();
            check_nominal("abt", n, 13'h1234, 2'd1);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_nominal("abt", 11, 13'h1234, 2'd1);
        for (int n = 12; n <= 15; n++) begin
            step();
            if (n == 14) start = 1'b0;
            expect_out($sformatf("abt flush n=%0d", n), 1'b1, 1'b0,
                       13'h0000, 4'h0, 3'b000, 2'b00, 1'b1);
            if (n == 13) begin
                start       = 1'b1;
                ctrl_a_mask = 13'h0FFF;
                sel_out     = 2'd0;
            end
        end
        step();
        expect_out("abt done", 1'b0, 1'b1, 13'h1FFF, 4'hF, 3'b111, 2'b11, 1'b0);
        for (int n = 17; n <= 20; n++) begin
            step();
            expect_idle($sformatf("abt idle n=%0d", n));
        end

        // start+abort together in IDLE: start wins, then back-to-back run
        launch("sa", 13'h1F00, 2'd3, 1'b1);
        follow_nominal("sa", 13'h1F00, 2'd3, 1'b1, 13'h0A5A, 2'd0);
        follow_nominal("b2b", 13'h0A5A, 2'd0, 1'b0, 13'h0, 2'd0);

        // Asynchronous reset in the middle of PUMP
        launch("rst", 13'h00FF, 2'd1, 1'b0);
        for (int n = 1; n <= 8; n++) begin
            step();
            check_nominal("rst", n, 13'h00FF, 2'd1);
        end
        #2;
        rst = 1'b1;
        #1;
        expect_idle("async rst");
        step();
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            expect_idle($sformatf("after rst %0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
